// File: rtl/serial_word_reader.sv
`timescale 1ns/1ps
// serial_word_reader: deserialises one bit-serial store word per request
// and holds it under a valid/ack handshake, with local digit/beat timing.
module serial_word_reader #(
    parameter int WORD_LENGTH  = 20,
    parameter int FLYBACK_TIME = 2,
    parameter int DIGIT_BITS   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   data_in,
    input  logic                   beat_sync,
    input  logic                   capture_req,
    input  logic                   word_ack,
    output logic [WORD_LENGTH-1:0] word_out,
    output logic                   word_valid,
    output logic                   busy,
    output logic                   flyback,
    output logic [DIGIT_BITS-1:0]  digit,
    output logic                   overrun
);

    localparam int BEAT_LEN = WORD_LENGTH + FLYBACK_TIME;
    localparam logic [DIGIT_BITS-1:0] LAST_DIGIT = DIGIT_BITS'(BEAT_LEN - 1);
    localparam logic [DIGIT_BITS-1:0] WORD_LAST  = DIGIT_BITS'(WORD_LENGTH - 1);
    localparam logic [DIGIT_BITS-1:0] FLY_FIRST  = DIGIT_BITS'(WORD_LENGTH);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT,
        HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WORD_LENGTH-2:0] shreg;
    logic                   start_ok;
    logic                   last_bit;
    logic                   sample;
    logic                   load;
    logic                   accept;

    assign start_ok   = (digit == '0) && !beat_sync;
    assign last_bit   = (digit == WORD_LAST);
    assign flyback    = (digit >= FLY_FIRST);
    assign word_valid = (state == HOLD);
    assign busy       = (state == ARMED) || (state == SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (beat_sync || digit == LAST_DIGIT) begin
            digit <= '0;
        end else begin
            digit <= digit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        load      = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture_req) begin
                    state_nxt = ARMED;
                    accept    = 1'b1;
                end
            end
            ARMED: begin
                if (start_ok) begin
                    state_nxt = SHIFT;
                    sample    = 1'b1;
                end
            end
            SHIFT: begin
                // a resync mid-word means the bits so far belong to no beat
                if (beat_sync) begin
                    state_nxt = ARMED;
                end else begin
                    sample = 1'b1;
                    if (last_bit) begin
                        state_nxt = HOLD;
                        load      = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (word_ack) begin
                    state_nxt = capture_req ? ARMED : IDLE;
                    accept    = capture_req;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg    <= '0;
            word_out <= '0;
            overrun  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                shreg <= '0;
            end else if (sample) begin
                for (int i = 0; i < WORD_LENGTH - 1; i++) begin
                    if (digit == DIGIT_BITS'(i)) begin
                        shreg[i] <= data_in;
                    end
                end
            end
            // top bit goes straight from the line into the held word
            if (load) begin
                word_out <= {data_in, shreg};
            end
            if (accept) begin
                overrun <= 1'b0;
            end else if (state == HOLD && capture_req && !word_ack) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_reader.sv
`timescale 1ns/1ps
// Scoreboard bench for serial_word_reader with a beat-level reference
// model built from recorded line history.
module tb_serial_word_reader;

    localparam int WL   = 20;
    localparam int FB   = 2;
    localparam int DB   = 5;
    localparam int BEAT = WL + FB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          data_in;
    logic          beat_sync;
    logic          capture_req;
    logic          word_ack;
    logic [WL-1:0] word_out;
    logic          word_valid;
    logic          busy;
    logic          flyback;
    logic [DB-1:0] digit;
    logic          overrun;

    always #5 clk = ~clk;

    serial_word_reader #(
        .WORD_LENGTH (WL),
        .FLYBACK_TIME(FB),
        .DIGIT_BITS  (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .beat_sync  (beat_sync),
        .capture_req(capture_req),
        .word_ack   (word_ack),
        .word_out   (word_out),
        .word_valid (word_valid),
        .busy       (busy),
        .flyback    (flyback),
        .digit      (digit),
        .overrun    (overrun)
    );

    typedef struct {
        logic [WL-1:0] word;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [WL-1:0] force_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    int            m_digit = 0;
    int            m_start = -1;
    int            cyc = 0;
    bit            m_wait = 0;
    bit            m_hold = 0;
    bit            m_ovr = 0;
    logic [WL-1:0] m_word = '0;
    bit            hist[int];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // reference: a capture is the WL line bits from an accepted beat start
    always @(posedge clk) begin
        hist[cyc] = data_in;
        if (!rst_n) begin
            m_digit = 0;
            m_start = -1;
            m_wait  = 0;
            m_hold  = 0;
            m_ovr   = 0;
            m_word  = '0;
        end else begin
            if (m_hold) begin
                if (word_ack) begin
                    m_hold = 0;
                    if (capture_req) begin
                        m_wait = 1;
                        m_ovr  = 0;
                    end
                end else if (capture_req) begin
                    m_ovr = 1;
                end
            end else if (m_start >= 0) begin
                if (beat_sync) begin
                    m_start = -1;
                    m_wait  = 1;
                end else if (cyc - m_start == WL - 1) begin
                    for (int i = 0; i < WL; i++) m_word[i] = hist[m_start + i];
                    sb.push_back('{word: m_word, cyc: cyc + 1});
                    m_start = -1;
                    m_hold  = 1;
                end
            end else if (m_wait) begin
                if (m_digit == 0 && !beat_sync) begin
                    m_start = cyc;
                    m_wait  = 0;
                end
            end else if (capture_req) begin
                m_wait = 1;
                m_ovr  = 0;
            end
            m_digit = beat_sync ? 0 : (m_digit + 1) % BEAT;
        end
        cyc++;
    end

    logic [WL-1:0] cur_word = '0;
    always @(negedge clk) begin
        if (m_digit == 0) begin
            if (force_q.size() > 0) cur_word = force_q.pop_front();
            else cur_word = WL'($urandom);
        end
        if (m_digit < WL) data_in = cur_word[m_digit];
        else data_in = 1'($urandom);
    end

    bit   prev_valid = 0;
    exp_t e;
    always @(negedge clk) begin
        check("digit", 64'(digit), 64'(m_digit));
        check("flyback", 64'(flyback), 64'(m_digit >= WL));
        check("busy", 64'(busy), 64'(m_wait || m_start >= 0));
        check("word_valid", 64'(word_valid), 64'(m_hold));
        check("overrun", 64'(overrun), 64'(m_ovr));
        check("word_out", 64'(word_out), 64'(m_word));
        if (word_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cap_unexpected: got word %0h expected none",
                         word_out);
            end else begin
                e = sb.pop_front();
                check("cap_word", 64'(word_out), 64'(e.word));
                check("cap_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        prev_valid = word_valid;
    end

    task automatic drive(bit s, bit r, bit a, bit rn = 1'b1);
        beat_sync   = s;
        capture_req = r;
        word_ack    = a;
        rst_n       = rn;
    endtask

    task automatic step(bit s, bit r, bit a, bit rn = 1'b1);
        @(negedge clk);
        #1;
        drive(s, r, a, rn);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic go_digit(int d);
        n_cmp++;
        for (int k = 0; k < 60; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (m_digit == d) return;
        end
        n_bad++;
        $display("FAIL go_digit: got timeout expected digit %0d", d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        data_in = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(23);

        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        force_q.push_back(20'h5A3C7);
        idle(46);

        force_q.push_back(20'hFFFFF);
        idle(30);
        step(1'b0, 1'b1, 1'b0);
        idle(2);

        step(1'b0, 1'b1, 1'b1);
        force_q.push_back(20'h00001);
        idle(46);

        step(1'b0, 1'b0, 1'b1);
        go_digit(20);
        drive(1'b0, 1'b1, 1'b0);
        go_digit(9);
        force_q.push_back(20'hABCDE);
        drive(1'b1, 1'b0, 1'b0);
        idle(46);
        step(1'b0, 1'b0, 1'b1);

        go_digit(20);
        drive(1'b0, 1'b1, 1'b0);
        go_digit(12);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        go_digit(20);
        drive(1'b0, 1'b1, 1'b0);
        force_q.push_back(20'h12345);
        idle(46);
        step(1'b0, 1'b0, 1'b1);
        idle(3);

        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 599) != 0);
        end

        step(1'b0, 1'b0, 1'b1);
        idle(5);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_word_reader.md
Name: serial_word_reader

Overview:
- Read-side counterpart to the bit-serial store write path.
- Deserialises the bit-serial word stream leaving a serial store (e.g. accumulator A_DATA_OUT) into a parallel word for the control/display logic.
- Keeps its own digit/beat timing (WORD_LENGTH digit periods + FLYBACK_TIME flyback periods per beat), re-alignable to the writer via beat_sync.
- Captures one word per request and holds it under a valid/ack handshake.

Parameters:
WORD_LENGTH, 20, bits per word = digit periods per beat
FLYBACK_TIME, 2, idle flyback periods after the last digit of each beat
DIGIT_BITS, 5, digit counter width; must satisfy 2^DIGIT_BITS >= WORD_LENGTH+FLYBACK_TIME

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset
data_in  input  1  serial data from store, LSB (digit 0) first, one bit per clk
beat_sync  input  1  writer's beat-start marker; forces digit counter to 0 next cycle
capture_req  input  1  level/pulse request to capture the next full word
word_ack  input  1  consumer accepts word_out
word_out  output  WORD_LENGTH  captured word; stable while word_valid=1
word_valid  output  1  word_out holds a complete captured word
busy  output  1  high in ARMED or SHIFT
flyback  output  1  high while digit >= WORD_LENGTH
digit  output  DIGIT_BITS  current digit-period index
overrun  output  1  sticky: capture_req seen while word_valid=1 and word_ack=0

Behaviour:
- Reset (rst_n=0 at an edge): digit=0, state=IDLE, word_out=0, word_valid=0, busy=0, overrun=0. flyback is combinational from digit, so it reads 0.
- Digit counter: free-running, 0 to WORD_LENGTH+FLYBACK_TIME-1, then wraps to 0.
  - beat_sync=1 at edge t gives digit=0 at t+1, overriding the increment and the wrap.
  - flyback = (digit >= WORD_LENGTH).
- FSM states: IDLE, ARMED, SHIFT, HOLD.
  - IDLE: capture_req=1 goes to ARMED. Shift register is cleared.
  - ARMED: waits for digit==0 with beat_sync=0. In that cycle it samples data_in into bit 0 and goes to SHIFT. A request made during flyback or mid-beat waits for the next digit 0.
  - SHIFT: at digit k (1 to WORD_LENGTH-1) samples data_in into bit k. At digit WORD_LENGTH-1 it loads the complete word into word_out and goes to HOLD. word_valid=1 from the following cycle.
  - Latency: word_valid rises exactly 1 clk after the digit WORD_LENGTH-1 sample. It rises WORD_LENGTH clks after the digit-0 sample. It is always in the first flyback period.
  - HOLD: word_out and word_valid are held until word_ack=1. On ack, word_valid=0 next cycle.
    - If capture_req=1 in the same cycle as word_ack, go to ARMED. Otherwise go to IDLE.
    - word_out keeps its value after ack until the next completed capture.
- beat_sync during SHIFT: discard the partial word and go to ARMED. Capture restarts at the new digit 0, the cycle after beat_sync. word_valid is unaffected.
- beat_sync during ARMED: the capture starts at the forced digit 0 on the next cycle, not in the current cycle.
- capture_req during ARMED or SHIFT is ignored; no queueing.
- overrun:
  - Set when capture_req=1 and word_ack=0 while in HOLD.
  - Cleared only by reset, or when a capture_req is accepted from IDLE or HOLD+ack.
- Bit order: word_out[i] = data_in sampled at digit i of the captured beat.
- Reset mid-capture: all state returns to reset values at that edge; any partial word is lost.

Test Plan:
- Reset → word_valid=0, word_out=0, digit=0, flyback=0, overrun=0. Release reset and run 22 clks → digit counts 0..21 and wraps to 0. flyback=1 only at digits 20 and 21.
- beat_sync, then capture_req in IDLE during digit 0; drive serial 0x5A3C7 LSB-first at digits 0..19 of the next beat → ARMED until that beat starts. word_valid=1 one clk after digit 19, word_out=0x5A3C7, busy=0.
- Hold word_ack=0 for 30 clks with a new serial word 0xFFFFF on data_in → word_out stays 0x5A3C7. Then pulse capture_req → overrun=1, word_valid stays 1.
- word_ack and capture_req together in HOLD; next beat carries 0x00001 → word_valid=0 next cycle, overrun=0, state ARMED. Then word_out=0x00001 with word_valid=1 one clk after digit 19.
- Assert beat_sync at digit 9 of a capture; next full beat carries 0xABCDE → partial word discarded, digit=0 next clk. Capture restarts and word_out=0xABCDE, with no word_valid pulse before that capture completes.
- rst_n=0 for one clk at digit 12 of a capture → all outputs at reset values, FSM IDLE. A later capture of 0x12345 completes correctly.
